// File: rtl/reset_sequencer_if.sv
// reset_sequencer_if: request inputs and staged reset outputs of the reset sequencer
interface reset_sequencer_if;
  logic       BTN_RESET_;
  logic       SW_RESET_REQ;
  logic       WDT_EN;
  logic       WDT_KICK;
  logic       PERIPH_RESET_;
  logic       CPU_RESET_;
  logic       BUSY;
  logic [1:0] CAUSE;
  modport slave (
    input  BTN_RESET_, SW_RESET_REQ, WDT_EN, WDT_KICK,
    output PERIPH_RESET_, CPU_RESET_, BUSY, CAUSE
  );
  modport master (
    output BTN_RESET_, SW_RESET_REQ, WDT_EN, WDT_KICK,
    input  PERIPH_RESET_, CPU_RESET_, BUSY, CAUSE
  );
endinterface

// File: rtl/reset_sequencer.sv
// reset_sequencer: merges POR, debounced button, software and watchdog requests into a
// held reset that releases peripherals first and the CPU a fixed gap later.
module reset_sequencer #(
  parameter int unsigned SYSCLK_MHZ  = 27,
  parameter int unsigned DEBOUNCE_US = 10000,
  parameter int unsigned HOLD_US     = 1000,
  parameter int unsigned GAP_US      = 100,
  parameter int unsigned WDT_US      = 500000
) (
  input logic              CLK,
  input logic              RESET_,
  reset_sequencer_if.slave bus
);
  localparam logic [31:0] DEBOUNCE_CYC = 32'(SYSCLK_MHZ * DEBOUNCE_US);
  localparam logic [31:0] HOLD_CYC     = 32'(SYSCLK_MHZ * HOLD_US);
  localparam logic [31:0] GAP_CYC      = 32'(SYSCLK_MHZ * GAP_US);
  localparam logic [31:0] WDT_CYC      = 32'(SYSCLK_MHZ * WDT_US);
  typedef enum logic [1:0] {ASSERT, REL_PERIPH, RUN} state_t;
  state_t      r_state, w_state_n;
  logic [31:0] r_hold, w_hold_n, r_gap, w_gap_n, r_wdt, w_wdt_n, r_deb;
  logic [1:0]  r_cause, w_cause_n;
  logic        r_sync1, r_sync2, r_armed, r_btn_req, r_periph, r_cpu;
  logic        w_deb_done, w_wdt_req, w_any_req;
  assign w_deb_done = r_deb == DEBOUNCE_CYC - 32'd1;
  // r_armed=1 waits for a low run (press), r_armed=0 waits for a high run (release);
  // starting disarmed stops the cleared synchronizer from looking like a press.
  always_ff @(posedge CLK or negedge RESET_)
    if (!RESET_) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_deb     <= '0;
      r_armed   <= 1'b0;
      r_btn_req <= 1'b0;
    end else begin
      r_sync1   <= bus.BTN_RESET_;
      r_sync2   <= r_sync1;
      r_deb     <= (r_sync2 == r_armed || w_deb_done) ? '0 : r_deb + 32'd1;
      r_armed   <= (r_sync2 != r_armed && w_deb_done) ? ~r_armed : r_armed;
      r_btn_req <= r_armed && !r_sync2 && w_deb_done;
    end
  assign w_wdt_req = r_state == RUN && bus.WDT_EN && !bus.WDT_KICK && r_wdt == WDT_CYC - 32'd1;
  assign w_any_req = r_btn_req || w_wdt_req || bus.SW_RESET_REQ;
  always_comb begin
    w_state_n = r_state;
    w_hold_n  = r_hold;
    w_gap_n   = r_gap;
    w_cause_n = r_cause;
    w_wdt_n   = (r_state == RUN && bus.WDT_EN && !bus.WDT_KICK) ? r_wdt + 32'd1 : '0;
    case (r_state)
      ASSERT: begin
        w_state_n = (r_hold == HOLD_CYC - 32'd1) ? REL_PERIPH : ASSERT;
        w_hold_n  = (r_hold == HOLD_CYC - 32'd1) ? '0 : r_hold + 32'd1;
      end
      REL_PERIPH: begin
        w_state_n = (r_gap == GAP_CYC - 32'd1) ? RUN : REL_PERIPH;
        w_gap_n   = (r_gap == GAP_CYC - 32'd1) ? '0 : r_gap + 32'd1;
      end
      default: ;
    endcase
    if (w_any_req) begin
      w_state_n = ASSERT;
      w_hold_n  = '0;
      w_gap_n   = '0;
      w_wdt_n   = '0;
      w_cause_n = r_btn_req ? 2'd1 : w_wdt_req ? 2'd3 : 2'd2;
    end
  end
  // outputs follow the next state so each release lands on the transition edge
  always_ff @(posedge CLK or negedge RESET_)
    if (!RESET_) begin
      r_state  <= ASSERT;
      r_hold   <= '0;
      r_gap    <= '0;
      r_wdt    <= '0;
      r_cause  <= 2'd0;
      r_periph <= 1'b0;
      r_cpu    <= 1'b0;
    end else begin
      r_state  <= w_state_n;
      r_hold   <= w_hold_n;
      r_gap    <= w_gap_n;
      r_wdt    <= w_wdt_n;
      r_cause  <= w_cause_n;
      r_periph <= w_state_n != ASSERT;
      r_cpu    <= w_state_n == RUN;
    end
  assign bus.PERIPH_RESET_ = r_periph;
  assign bus.CPU_RESET_    = r_cpu;
  assign bus.BUSY          = r_state != RUN;
  assign bus.CAUSE         = r_cause;
endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: vector table, directed corner sequences and random stimulus
// checked against a time-since-request reference model.
module tb_reset_sequencer;
  localparam int DEB = 4, HOLD = 8, GAP = 2, WDT = 16;
  logic clk = 1'b0, rst_n = 1'b0;
  int n_tests = 0, n_fail = 0;
  reset_sequencer_if bus();
  reset_sequencer #(.SYSCLK_MHZ(1), .DEBOUNCE_US(DEB), .HOLD_US(HOLD), .GAP_US(GAP), .WDT_US(WDT))
    dut (.CLK(clk), .RESET_(rst_n), .bus(bus));
  always #5 clk = ~clk;
  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
  // Model: edges since last sequence start decide both outputs; button via run lengths.
  int m_t = 0, m_wcnt = 0, m_runl = 0;
  logic [1:0] m_cause = 2'd0;
  logic m_h1 = 0, m_h2 = 0, m_cur = 0, m_armed = 0, m_pend = 0, m_run, m_wreq, m_ds;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_t = 0; m_wcnt = 0; m_runl = 0; m_cause = 2'd0;
      m_h1 = 0; m_h2 = 0; m_cur = 0; m_armed = 0; m_pend = 0;
    end else begin
      m_run  = m_t >= HOLD + GAP;
      m_wreq = m_run && bus.WDT_EN && !bus.WDT_KICK && m_wcnt == WDT - 1;
      if (m_pend || m_wreq || bus.SW_RESET_REQ) begin
        m_cause = m_pend ? 2'd1 : m_wreq ? 2'd3 : 2'd2;
        m_t = 0;
        m_wcnt = 0;
      end else begin
        m_wcnt = (m_run && bus.WDT_EN && !bus.WDT_KICK) ? m_wcnt + 1 : 0;
        if (m_t < 1000) m_t++;
      end
      m_ds = m_h2; m_h2 = m_h1; m_h1 = bus.BTN_RESET_;
      if (m_ds == m_cur) m_runl++;
      else begin m_cur = m_ds; m_runl = 1; end
      m_pend = 0;
      if (m_runl == DEB && !m_cur && m_armed) begin m_pend = 1; m_armed = 0; end
      else if (m_runl == DEB && m_cur && !m_armed) m_armed = 1;
    end
  end
  typedef struct {int n; logic btn, sw, en, kick, p, c, b; logic [1:0] cause;} vec_t;
  vec_t tbl[9];
  task automatic drive(input logic btn, sw, en, kick);
    bus.BTN_RESET_ = btn; bus.SW_RESET_REQ = sw; bus.WDT_EN = en; bus.WDT_KICK = kick;
  endtask
  task automatic tick;
    @(posedge clk); #1;
  endtask
  task automatic check(input string name, input logic p, c, b, input logic [1:0] cs);
    n_tests++;
    if ({bus.PERIPH_RESET_, bus.CPU_RESET_, bus.BUSY, bus.CAUSE} !== {p, c, b, cs}) begin
      n_fail++;
      $display("FAIL %s: got periph=%b cpu=%b busy=%b cause=%0d, want periph=%b cpu=%b busy=%b cause=%0d",
               name, bus.PERIPH_RESET_, bus.CPU_RESET_, bus.BUSY, bus.CAUSE, p, c, b, cs);
    end
  endtask
  initial begin
    logic btn;
    tbl[0] = '{7, 1, 0, 0, 0, 0, 0, 1, 2'd0};
    tbl[1] = '{2, 1, 0, 0, 0, 1, 0, 1, 2'd0};
    tbl[2] = '{2, 1, 0, 0, 0, 1, 1, 0, 2'd0};
    tbl[3] = '{1, 1, 1, 0, 0, 0, 0, 1, 2'd2};
    tbl[4] = '{4, 1, 0, 0, 0, 0, 0, 1, 2'd2};
    tbl[5] = '{1, 1, 1, 0, 0, 0, 0, 1, 2'd2};
    tbl[6] = '{7, 1, 0, 0, 0, 0, 0, 1, 2'd2};
    tbl[7] = '{2, 1, 0, 0, 0, 1, 0, 1, 2'd2};
    tbl[8] = '{2, 1, 0, 0, 0, 1, 1, 0, 2'd2};
    drive(1, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1 check("reset", 0, 0, 1, 2'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 9; i++)
      for (int k = 0; k < tbl[i].n; k++) begin
        drive(tbl[i].btn, tbl[i].sw, tbl[i].en, tbl[i].kick);
        tick();
        check($sformatf("por_sw[%0d.%0d]", i, k), tbl[i].p, tbl[i].c, tbl[i].b, tbl[i].cause);
      end
    for (int i = 1; i <= 16; i++) begin
      drive(i > 3, 0, 0, 0);
      tick();
      check("btn_short", 1, 1, 0, 2'd2);
    end
    for (int i = 1; i <= 40; i++) begin
      drive(i > 10, 0, 0, 0);
      tick();
      check($sformatf("btn_long[%0d]", i), !(i >= 7 && i < 15), !(i >= 7 && i < 17),
            i >= 7 && i < 17, i < 7 ? 2'd2 : 2'd1);
    end
    drive(1, 1, 1, 0);
    tick();
    check("wdt_sw", 0, 0, 1, 2'd2);
    for (int i = 1; i <= 26; i++) begin
      drive(1, 0, 1, 0);
      tick();
      if (i < 26) check($sformatf("wdt_run[%0d]", i), i >= 8, i >= 10, i < 10, 2'd2);
      else check("wdt_timeout", 0, 0, 1, 2'd3);
    end
    for (int j = 0; j < 230; j++) begin
      drive(1, 0, 1, j % 10 == 0);
      tick();
      if (j >= 10) check("wdt_kicked", 1, 1, 0, 2'd3);
    end
    for (int j = 0; j < 37; j++) begin
      drive(1, 0, 1, j == 0 || j == 16 || (j > 16 && j % 5 == 0));
      tick();
      check($sformatf("wdt_kick_edge[%0d]", j), 1, 1, 0, 2'd3);
    end
    for (int i = 1; i <= 15; i++) begin
      drive(i > 7, i == 7, 0, 0);
      tick();
      if (i < 7) check("simul_pre", 1, 1, 0, 2'd3);
      else check($sformatf("simul[%0d]", i), i == 15, 0, 1, 2'd1);
    end
    #2 rst_n = 1'b0;
    #1 check("async_reset", 0, 0, 1, 2'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      check($sformatf("por2[%0d]", i), i >= 8, i >= 10, i < 10, 2'd0);
    end
    btn = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) btn = ~btn;
      drive(btn, $urandom_range(0, 39) == 0, $urandom_range(0, 9) != 0, $urandom_range(0, 11) == 0);
      if ($urandom_range(0, 499) == 0) begin
        #2 rst_n = 1'b0;
        #3 rst_n = 1'b1;
      end
      tick();
      check($sformatf("rand[%0d]", i), m_t >= HOLD, m_t >= HOLD + GAP, m_t < HOLD + GAP, m_cause);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
